// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_pkg
//  Purpose  : Shared state encoding, RV32I funct3 codes and the access
//             legality check for the load/store unit.
//  Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsuState_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned variants only exist for loads; stores accept B/H/W only.
    function automatic logic accessLegal(input logic isStore,
                                         input logic [2:0] funct3,
                                         input logic [1:0] addrLo);
        logic ok;
        ok = 1'b0;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_H:    ok = !addrLo[0];
            F3_W:    ok = (addrLo == 2'b00);
            F3_BU:   ok = !isStore;
            F3_HU:   ok = !isStore && !addrLo[0];
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_load_align
//  Purpose  : Selects the addressed byte/half lane of a bus read word and
//             sign- or zero-extends it according to funct3.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] rdata,
    output logic [31:0] loadData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = rdata[7:0];
        case (addrLo)
            2'd0:    w_byte = rdata[7:0];
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            default: w_byte = rdata[31:24];
        endcase
        w_half = addrLo[1] ? rdata[31:16] : rdata[15:0];
    end

    always_comb begin
        loadData = '0;
        case (funct3)
            F3_B:    loadData = {{24{w_byte[7]}}, w_byte};
            F3_H:    loadData = {{16{w_half[15]}}, w_half};
            F3_W:    loadData = rdata;
            F3_BU:   loadData = {24'd0, w_byte};
            F3_HU:   loadData = {16'd0, w_half};
            default: loadData = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : MEM-stage load/store unit driving a valid/ack data bus.
//             Define LSU_TIMEOUT_EN to abort BUSY after TIMEOUT_CYCLES.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int XLEN = 32
`ifdef LSU_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [2:0]      Funct3M,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic [XLEN-1:0] ReadDataM,
    output logic            StallM,
    output logic            LsuErrM,
    output logic            bus_req,
    output logic            bus_we,
    output logic [XLEN-1:0] bus_addr,
    output logic [3:0]      bus_be,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ack,
    input  logic [XLEN-1:0] bus_rdata
);

    lsuState_t       r_state, w_nextState;
    logic [2:0]      r_funct3;
    logic [1:0]      r_addrLo;
    logic [XLEN-1:0] r_rdata;
    logic [XLEN-1:0] w_loadData;
    logic            w_access, w_legal, w_start, w_timeout, w_toErr;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;

    lsu_load_align u_align (
        .funct3   (r_funct3),
        .addrLo   (r_addrLo),
        .rdata    (bus_rdata),
        .loadData (w_loadData)
    );

    // A simultaneous read+write is handled as a store.
    assign w_access = MemReadM | MemWriteM;
    assign w_legal  = accessLegal(MemWriteM, Funct3M, ALUResultM[1:0]);
    assign w_start  = (r_state == IDLE) && w_access && w_legal;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = WriteDataM;
        case (Funct3M[1:0])
            2'b00: begin
                w_be    = 4'b0001 << ALUResultM[1:0];
                w_wdata = {4{WriteDataM[7:0]}};
            end
            2'b01: begin
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{WriteDataM[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = WriteDataM;
            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] c_TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] r_count;
    logic       r_toErr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_toErr <= 1'b0;
        end else begin
            r_count <= (r_state == BUSY) ? r_count + 8'd1 : 8'd0;
            r_toErr <= w_timeout;
        end
    end

    assign w_timeout = (r_state == BUSY) && !bus_ack && (r_count == c_TO_LAST);
    assign w_toErr   = r_toErr;
`else
    assign w_timeout = 1'b0;
    assign w_toErr   = 1'b0;
`endif

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_start) w_nextState = BUSY;
            BUSY:    if (bus_ack || w_timeout) w_nextState = DONE;
            DONE:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_be    <= '0;
            bus_wdata <= '0;
            r_funct3  <= '0;
            r_addrLo  <= '0;
            r_rdata   <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_start) begin
                bus_req   <= 1'b1;
                bus_we    <= MemWriteM;
                bus_addr  <= {ALUResultM[XLEN-1:2], 2'b00};
                bus_be    <= w_be;
                bus_wdata <= w_wdata;
                r_funct3  <= Funct3M;
                r_addrLo  <= ALUResultM[1:0];
            end else if (r_state == BUSY && (bus_ack || w_timeout)) begin
                bus_req <= 1'b0;
                r_rdata <= (bus_ack && !bus_we) ? w_loadData : '0;
            end
        end
    end

    // Load data is presented only while the instruction is retiring from MEM.
    assign ReadDataM = (r_state == DONE) ? r_rdata : '0;
    assign StallM    = w_start || (r_state == BUSY);
    assign LsuErrM   = ((r_state == IDLE) && w_access && !w_legal) || w_toErr;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Directed, table-driven self-checking bench for load_store_unit.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemReadM, MemWriteM;
    logic [2:0]  Funct3M;
    logic [31:0] ALUResultM, WriteDataM, ReadDataM;
    logic        StallM, LsuErrM;
    logic        bus_req, bus_we, bus_ack;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_be;

    load_store_unit #(
        .XLEN(32)
`ifdef LSU_TIMEOUT_EN
        , .TIMEOUT_CYCLES(4)
`endif
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .Funct3M    (Funct3M),
        .ALUResultM (ALUResultM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .LsuErrM    (LsuErrM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_be     (bus_be),
        .bus_wdata  (bus_wdata),
        .bus_ack    (bus_ack),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wd;
        int          ackWait;
        logic [31:0] rdata;
        logic        expErr;
        logic [3:0]  expBe;
        logic [31:0] expWdata;
        logic [31:0] expRead;
    } vec_t;

    vec_t vecs[15];
    int   nPass = 0;
    int   nTotal = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic idleInputs();
        MemReadM   = 1'b0;
        MemWriteM  = 1'b0;
        Funct3M    = 3'b000;
        ALUResultM = '0;
        WriteDataM = '0;
    endtask

    task automatic runVec(input vec_t v);
        int stalls;
        @(negedge clk);
        MemReadM   = v.rd;
        MemWriteM  = v.wr;
        Funct3M    = v.f3;
        ALUResultM = v.addr;
        WriteDataM = v.wd;
        #1;
        stalls = int'(StallM);
        if (v.expErr) begin
            check({v.name, " err"}, 32'(LsuErrM), 32'd1);
            check({v.name, " stall"}, 32'(StallM), 32'd0);
            check({v.name, " rdata"}, ReadDataM, 32'd0);
            @(negedge clk);
            idleInputs();
            #1;
            check({v.name, " no req"}, 32'(bus_req), 32'd0);
            check({v.name, " err clr"}, 32'(LsuErrM), 32'd0);
            return;
        end
        check({v.name, " err idle"}, 32'(LsuErrM), 32'd0);
        @(negedge clk);
        #1;
        check({v.name, " req"}, 32'(bus_req), 32'd1);
        check({v.name, " we"}, 32'(bus_we), 32'(v.wr));
        check({v.name, " addr"}, bus_addr, v.addr & 32'hFFFF_FFFC);
        check({v.name, " be"}, 32'(bus_be), 32'(v.expBe));
        check({v.name, " wdata"}, bus_wdata, v.expWdata);
        stalls += int'(StallM);
        for (int i = 0; i < v.ackWait; i++) begin
            @(negedge clk);
            #1;
            stalls += int'(StallM);
        end
        bus_ack   = 1'b1;
        bus_rdata = v.rdata;
        @(negedge clk);
        bus_ack   = 1'b0;
        bus_rdata = 32'h5555_5555;
        idleInputs();
        #1;
        check({v.name, " done stall"}, 32'(StallM), 32'd0);
        check({v.name, " readData"}, ReadDataM, v.expRead);
        check({v.name, " done req"}, 32'(bus_req), 32'd0);
        check({v.name, " stall cycles"}, 32'(stalls), 32'(v.ackWait + 2));
        @(negedge clk);
        #1;
        check({v.name, " idle readData"}, ReadDataM, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //          name     rd    wr    f3      addr          wd            wait rdata         err   be       wdata         read
        vecs[0]  = '{"LW",   1'b1, 1'b0, F3_W,   32'h100,      32'h0,        1,   32'hCAFEBABE, 1'b0, 4'b1111, 32'h0,        32'hCAFEBABE};
        vecs[1]  = '{"SB",   1'b0, 1'b1, F3_B,   32'h203,      32'h000000A5, 2,   32'h0,        1'b0, 4'b1000, 32'hA5A5A5A5, 32'h0};
        vecs[2]  = '{"LB",   1'b1, 1'b0, F3_B,   32'h1,        32'h0,        0,   32'h00008000, 1'b0, 4'b0010, 32'h0,        32'hFFFFFF80};
        vecs[3]  = '{"LHU",  1'b1, 1'b0, F3_HU,  32'h2,        32'h0,        1,   32'h80010000, 1'b0, 4'b1100, 32'h0,        32'h00008001};
        vecs[4]  = '{"LWmis",1'b1, 1'b0, F3_W,   32'h102,      32'h0,        0,   32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[5]  = '{"SH",   1'b0, 1'b1, F3_H,   32'h2,        32'h1234ABCD, 0,   32'h0,        1'b0, 4'b1100, 32'hABCDABCD, 32'h0};
        vecs[6]  = '{"SW",   1'b0, 1'b1, F3_W,   32'h10,       32'hDEADBEEF, 3,   32'h0,        1'b0, 4'b1111, 32'hDEADBEEF, 32'h0};
        vecs[7]  = '{"LH",   1'b1, 1'b0, F3_H,   32'h6,        32'h0,        0,   32'h9ABC0000, 1'b0, 4'b1100, 32'h0,        32'hFFFF9ABC};
        vecs[8]  = '{"LBU",  1'b1, 1'b0, F3_BU,  32'h3,        32'h0,        0,   32'hF0000000, 1'b0, 4'b1000, 32'h0,        32'h000000F0};
        vecs[9]  = '{"SHmis",1'b0, 1'b1, F3_H,   32'h1,        32'h0,        0,   32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{"LF3",  1'b1, 1'b0, 3'b011, 32'h0,        32'h0,        0,   32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{"SF3",  1'b0, 1'b1, F3_BU,  32'h0,        32'h0,        0,   32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[12] = '{"RW",   1'b1, 1'b1, F3_W,   32'h44,       32'h01020304, 0,   32'hFFFFFFFF, 1'b0, 4'b1111, 32'h01020304, 32'h0};
        vecs[13] = '{"LH0",  1'b1, 1'b0, F3_H,   32'h8,        32'h0,        0,   32'h12347FFF, 1'b0, 4'b0011, 32'h0,        32'h00007FFF};
        vecs[14] = '{"LB2",  1'b1, 1'b0, F3_B,   32'h2,        32'h0,        0,   32'h00550000, 1'b0, 4'b0100, 32'h0,        32'h00000055};

        reset     = 1'b1;
        bus_ack   = 1'b0;
        bus_rdata = '0;
        idleInputs();
        repeat (2) @(negedge clk);
        #1;
        check("rst ReadDataM", ReadDataM, 32'd0);
        check("rst StallM", 32'(StallM), 32'd0);
        check("rst LsuErrM", 32'(LsuErrM), 32'd0);
        check("rst bus_req", 32'(bus_req), 32'd0);
        check("rst bus_we", 32'(bus_we), 32'd0);
        check("rst bus_addr", bus_addr, 32'd0);
        check("rst bus_be", 32'(bus_be), 32'd0);
        check("rst bus_wdata", bus_wdata, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) runVec(vecs[i]);

        // Stray ack while idle must not start anything.
        @(negedge clk);
        bus_ack   = 1'b1;
        bus_rdata = 32'h1111_2222;
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("stray ack req", 32'(bus_req), 32'd0);
        check("stray ack stall", 32'(StallM), 32'd0);
        check("stray ack rdata", ReadDataM, 32'd0);

        // Reset while BUSY, followed by a late ack.
        @(negedge clk);
        MemReadM   = 1'b1;
        Funct3M    = F3_W;
        ALUResultM = 32'h40;
        @(negedge clk);
        #1;
        check("rstBusy req", 32'(bus_req), 32'd1);
        reset = 1'b1;
        idleInputs();
        @(negedge clk);
        reset     = 1'b0;
        bus_ack   = 1'b1;
        bus_rdata = 32'h7777_8888;
        #1;
        check("rstBusy req clr", 32'(bus_req), 32'd0);
        check("rstBusy stall", 32'(StallM), 32'd0);
        @(negedge clk);
        bus_ack = 1'b0;
        #1;
        check("late ack rdata", ReadDataM, 32'd0);
        check("late ack stall", 32'(StallM), 32'd0);
        check("late ack req", 32'(bus_req), 32'd0);

`ifdef LSU_TIMEOUT_EN
        @(negedge clk);
        MemReadM   = 1'b1;
        Funct3M    = F3_W;
        ALUResultM = 32'h80;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idleInputs();
            #1;
            check("to busy stall", 32'(StallM), 32'd1);
            check("to busy err", 32'(LsuErrM), 32'd0);
        end
        @(negedge clk);
        #1;
        check("to err", 32'(LsuErrM), 32'd1);
        check("to stall", 32'(StallM), 32'd0);
        check("to rdata", ReadDataM, 32'd0);
        check("to req", 32'(bus_req), 32'd0);
        @(negedge clk);
        #1;
        check("to err clr", 32'(LsuErrM), 32'd0);
`endif

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire
